// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns (gfedcba, active-low),
// anode select codes and the capture state machine encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;

  localparam logic [3:0] AN_TENTH  = 4'b1110;
  localparam logic [3:0] AN_SEC    = 4'b1101;
  localparam logic [3:0] AN_TENSEC = 4'b1011;
  localparam logic [3:0] AN_MIN    = 4'b0111;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_SETTLE = 2'd1,
    CAP_LOCKED = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] slot;
  } an_sel_t;

  // Exactly one low anode selects a slot; blank or multiple lows select nothing.
  function automatic an_sel_t an_decode(input logic [3:0] an);
    an_sel_t r;
    r.valid = 1'b1;
    r.slot  = 2'd0;
    case (an)
      AN_TENTH:  r.slot = 2'd0;
      AN_SEC:    r.slot = 2'd1;
      AN_TENSEC: r.slot = 2'd2;
      AN_MIN:    r.slot = 2'd3;
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; hit_o is low for any
// pattern outside the ten digit shapes.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] bcd_o,
  output logic       hit_o
);

  always_comb begin
    bcd_o = 4'd0;
    hit_o = 1'b1;
    case (pattern_i)
      SEG_ZERO:  bcd_o = 4'd0;
      SEG_ONE:   bcd_o = 4'd1;
      SEG_TWO:   bcd_o = 4'd2;
      SEG_THREE: bcd_o = 4'd3;
      SEG_FOUR:  bcd_o = 4'd4;
      SEG_FIVE:  bcd_o = 4'd5;
      SEG_SIX:   bcd_o = 4'd6;
      SEG_SEVEN: bcd_o = 4'd7;
      SEG_EIGHT: bcd_o = 4'd8;
      SEG_NINE:  bcd_o = 4'd9;
      default:   hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Multiplexed seven-segment bus monitor: rebuilds the four timer digits.
// Optional SEG_CAPTURE_DP_EN captures decimal points into dp_out.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic       basys_clk,
  input  logic       reset,
  input  logic [7:0] seg_in,
  input  logic [3:0] an_in,
  output logic [3:0] tenth,
  output logic [3:0] sec,
  output logic [3:0] tensec,
  output logic [3:0] min,
  output logic [3:0] digit_valid,
  output logic       frame_strobe,
  output logic       bad_pattern,
  output logic [3:0] dp_out,
  output cap_state_e dbg_state
);

`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] SEG_MASK = 8'hFF;
`else
  localparam logic [7:0] SEG_MASK = 8'h7F;
`endif
  localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYCLES);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

  logic [3:0]       an_s1_q, an_smp_q;
  logic [7:0]       seg_s1_q, seg_smp_q;
  logic [11:0]      word_in, word_smp;
  an_sel_t          sel_in;
  logic [7:0]       cnt_q, cnt_d;
  cap_state_e       state_q, state_d;
  logic             accept_d, acc_q;
  logic [1:0]       acc_slot_q;
  logic [6:0]       acc_pat_q;
  logic [31:0]      wd_q;
  logic             timeout_d;
  logic [3:0]       dec_bcd;
  logic             dec_hit;
  logic [3:0][3:0]  digits_q;
  logic [3:0]       valid_q, seen_q, seen_set;
  logic             frame_q, bad_q;

  // Idle bus is all ones, so the synchroniser resets to 1s.
  always_ff @(posedge basys_clk) begin
    if (reset) begin
      an_s1_q   <= '1;
      an_smp_q  <= '1;
      seg_s1_q  <= '1;
      seg_smp_q <= '1;
    end else begin
      an_s1_q   <= an_in;
      an_smp_q  <= an_s1_q;
      seg_s1_q  <= seg_in;
      seg_smp_q <= seg_s1_q;
    end
  end

  // word_in is the sample about to be taken; word_smp is the previous one.
  assign word_in  = {an_s1_q, seg_s1_q & SEG_MASK};
  assign word_smp = {an_smp_q, seg_smp_q & SEG_MASK};
  assign sel_in   = an_decode(an_s1_q);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (word_in != word_smp || !sel_in.valid) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= STABLE_W) begin
      cnt_d = STABLE_W;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (sel_in.valid) state_d = CAP_SETTLE;
      end
      CAP_SETTLE: begin
        if (!sel_in.valid) begin
          state_d = CAP_IDLE;
        end else if (cnt_d == STABLE_W) begin
          state_d  = CAP_LOCKED;
          accept_d = 1'b1;
        end
      end
      CAP_LOCKED: begin
        if (!sel_in.valid) state_d = CAP_IDLE;
        else if (word_in != word_smp) state_d = CAP_SETTLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      state_q    <= CAP_IDLE;
      cnt_q      <= 8'd0;
      acc_q      <= 1'b0;
      acc_slot_q <= 2'd0;
      acc_pat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= accept_d;
      if (accept_d) begin
        acc_slot_q <= sel_in.slot;
        acc_pat_q  <= seg_s1_q[6:0];
      end
    end
  end

  // Acceptance takes priority over an expiring watchdog.
  assign timeout_d = !accept_d && (wd_q + 32'd1 == TIMEOUT_W);

  always_ff @(posedge basys_clk) begin
    if (reset || accept_d || timeout_d) wd_q <= 32'd0;
    else wd_q <= wd_q + 32'd1;
  end

  seg_pattern_decode u_decode (
    .pattern_i (acc_pat_q),
    .bcd_o     (dec_bcd),
    .hit_o     (dec_hit)
  );

  assign seen_set = seen_q | (4'b0001 << acc_slot_q);

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      digits_q <= '0;
      valid_q  <= 4'd0;
      seen_q   <= 4'd0;
      frame_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      bad_q   <= 1'b0;
      if (acc_q) begin
        if (dec_hit) begin
          digits_q[acc_slot_q] <= dec_bcd;
          valid_q[acc_slot_q]  <= 1'b1;
          if (seen_set == 4'b1111) begin
            frame_q <= 1'b1;
            seen_q  <= 4'd0;
          end else begin
            seen_q <= seen_set;
          end
        end else begin
          bad_q               <= 1'b1;
          valid_q[acc_slot_q] <= 1'b0;
        end
      end else if (timeout_d) begin
        valid_q <= 4'd0;
        seen_q  <= 4'd0;
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic       acc_dp_q;
  logic [3:0] dp_q;

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      acc_dp_q <= 1'b0;
      dp_q     <= 4'd0;
    end else begin
      if (accept_d) acc_dp_q <= ~seg_s1_q[7];
      if (acc_q && dec_hit) dp_q[acc_slot_q] <= acc_dp_q;
    end
  end

  assign dp_out = dp_q;
`else
  assign dp_out = 4'd0;
`endif

  assign tenth        = digits_q[0];
  assign sec          = digits_q[1];
  assign tensec       = digits_q[2];
  assign min          = digits_q[3];
  assign digit_valid  = valid_q;
  assign frame_strobe = frame_q;
  assign bad_pattern  = bad_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed vector table, hand sequences and a
// randomized run checked every cycle against a dwell-level reference model.
module tb_seven_seg_capture;
  import seven_seg_pkg::*;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 400;

  logic       basys_clk = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic [3:0] an_in;
  logic [3:0] tenth, sec, tensec, min, digit_valid, dp_out;
  logic       frame_strobe, bad_pattern;
  cap_state_e dbg_state;

  seven_seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .basys_clk    (basys_clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .tenth        (tenth),
    .sec          (sec),
    .tensec       (tensec),
    .min          (min),
    .digit_valid  (digit_valid),
    .frame_strobe (frame_strobe),
    .bad_pattern  (bad_pattern),
    .dp_out       (dp_out),
    .dbg_state    (dbg_state)
  );

  always #5 basys_clk = ~basys_clk;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0;
  int bad_cnt = 0;

  logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  logic [3:0] slot_codes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // ---------------- reference model ----------------
  typedef struct {
    int         acc_edge;
    int         slot;
    logic [6:0] pat;
    logic       dp;
  } ev_t;

  ev_t        evq[$];
  int         edge_n = 0;
  int         prev_word = -1;
  int         run = 0;
  int         wd_base = 0;
  bit         rst_pending = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_valid, m_seen, m_dp;
  logic       m_frame, m_bad;

  function automatic int slot_of(input logic [3:0] an);
    for (int i = 0; i < 4; i++) if (slot_codes[i] == an) return i;
    return -1;
  endfunction

  function automatic int ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  // Called with the pin values that the next clock edge will capture.
  task automatic model_drive(input logic [3:0] an, input logic [7:0] seg, input bit rst);
    int  w;
    int  s;
    ev_t ev;
    if (rst) begin
      rst_pending = 1;
      prev_word = -1;
      run = 0;
      evq.delete();
      return;
    end
`ifdef SEG_CAPTURE_DP_EN
    w = int'({an, seg});
`else
    w = int'({an, seg[6:0]});
`endif
    s = slot_of(an);
    if (s >= 0 && w == prev_word) run++;
    else run = (s >= 0) ? 1 : 0;
    prev_word = w;
    if (s >= 0 && run == STABLE) begin
      // pin cycle edge_n is captured at edge_n+1 and sampled at edge_n+2
      ev.acc_edge = edge_n + 2;
      ev.slot = s;
      ev.pat = seg[6:0];
      ev.dp = ~seg[7];
      evq.push_back(ev);
    end
  endtask

  task automatic model_edge();
    bit acc_now;
    int d;
    edge_n++;
    m_frame = 0;
    m_bad = 0;
    if (rst_pending) begin
      rst_pending = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_valid = 0; m_seen = 0; m_dp = 0;
      wd_base = edge_n;
      return;
    end
    if (evq.size() > 0 && evq[0].acc_edge + 1 == edge_n) begin
      d = ref_decode(evq[0].pat);
      if (d >= 0) begin
        m_dig[evq[0].slot] = 4'(d);
        m_valid[evq[0].slot] = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
        m_dp[evq[0].slot] = evq[0].dp;
`endif
        m_seen[evq[0].slot] = 1'b1;
        if (m_seen == 4'b1111) begin
          m_frame = 1;
          m_seen = 0;
        end
      end else begin
        m_bad = 1;
        m_valid[evq[0].slot] = 1'b0;
      end
      void'(evq.pop_front());
    end
    acc_now = (evq.size() > 0 && evq[0].acc_edge == edge_n);
    if (acc_now) wd_base = edge_n;
    else if (edge_n - wd_base == TIMEOUT) begin
      m_valid = 0;
      m_seen = 0;
      wd_base = edge_n;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [25:0] got, exp;
    got = {tenth, sec, tensec, min, digit_valid, frame_strobe, bad_pattern, dp_out};
    exp = {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_valid, m_frame, m_bad, m_dp};
    check($sformatf("model_edge%0d", edge_n), 32'(got), 32'(exp));
    if (frame_strobe === 1'b1) frame_cnt++;
    if (bad_pattern === 1'b1) bad_cnt++;
  endtask

  // One clock: drive pins, advance model past the edge, compare at negedge.
  task automatic step(input logic [3:0] an, input logic [7:0] seg, input bit rst);
    an_in = an;
    seg_in = seg;
    reset = rst;
    model_drive(an, seg, rst);
    @(posedge basys_clk);
    model_edge();
    @(negedge basys_clk);
    check_cycle();
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    for (int k = 0; k < n; k++) step(an, seg, 0);
  endtask

  function automatic logic [15:0] dut_digits();
    return {min, tensec, sec, tenth};
  endfunction

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int          cycles;
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid;
    int          exp_frames;
    int          exp_bads;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{4'b1110, 8'hF9, 10, 16'h0001, 4'b0001, 0, 0};
    vecs[1]  = '{4'b1101, 8'h92, 10, 16'h0051, 4'b0011, 0, 0};
    vecs[2]  = '{4'b1011, 8'hA4, 10, 16'h0251, 4'b0111, 0, 0};
    vecs[3]  = '{4'b0111, 8'hC0, 10, 16'h0251, 4'b1111, 1, 0};
    vecs[4]  = '{4'b1101, 8'h80,  3, 16'h0251, 4'b1111, 0, 0};
    vecs[5]  = '{4'b1111, 8'hC0,  5, 16'h0251, 4'b1111, 0, 0};
    vecs[6]  = '{4'b1011, 8'hBF, 10, 16'h0251, 4'b1011, 0, 1};
    vecs[7]  = '{4'b1110, 8'hF8, 10, 16'h0257, 4'b1011, 0, 0};
    vecs[8]  = '{4'b1101, 8'h90, 10, 16'h0297, 4'b1011, 0, 0};
    vecs[9]  = '{4'b0111, 8'hB0, 10, 16'h3297, 4'b1011, 0, 0};
    vecs[10] = '{4'b1011, 8'h99, 10, 16'h3497, 4'b1111, 1, 0};

    // reset
    step(4'hF, 8'hFF, 1);
    step(4'hF, 8'hFF, 1);
    check("reset_outputs",
          32'({tenth, sec, tensec, min, digit_valid, frame_strobe, bad_pattern, dp_out}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(CAP_IDLE));

    // directed frame, glitch rejection and bad pattern
    for (int v = 0; v < 11; v++) begin
      frame_cnt = 0;
      bad_cnt = 0;
      hold(vecs[v].an, vecs[v].seg, vecs[v].cycles);
      check($sformatf("vec%0d_digits", v), 32'(dut_digits()), 32'(vecs[v].exp_digits));
      check($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_frames", v), frame_cnt, vecs[v].exp_frames);
      check($sformatf("vec%0d_bads", v), bad_cnt, vecs[v].exp_bads);
    end

    // watchdog: valid survives just short of the timeout, clears after it
    hold(4'hF, 8'hFF, TIMEOUT - 20);
    check("wd_before_valid", 32'(digit_valid), 32'hF);
    hold(4'hF, 8'hFF, 40);
    check("wd_after_valid", 32'(digit_valid), 32'h0);
    check("wd_digits_held", 32'(dut_digits()), 32'h3497);
    hold(4'b1101, 8'h82, 10);
    check("wd_one_digit_valid", 32'(digit_valid), 32'b0010);
    check("wd_one_digit_value", 32'(dut_digits()), 32'h3467);
    check("locked_state", 32'(dbg_state), 32'(CAP_LOCKED));

    // mid-dwell reset, then exact acceptance latency of a fresh dwell
    hold(4'b1110, 8'h80, 3);
    step(4'b1110, 8'h80, 1);
    check("midreset_outputs",
          32'({tenth, sec, tensec, min, digit_valid, frame_strobe, bad_pattern, dp_out}), 32'd0);
    hold(4'b1110, 8'h82, 5);
    check("latency_5_tenth", 32'(tenth), 32'd0);
    check("latency_5_valid", 32'(digit_valid), 32'd0);
    step(4'b1110, 8'h82, 0);
    check("latency_6_tenth", 32'(tenth), 32'd6);
    check("latency_6_valid", 32'(digit_valid), 32'b0001);
    hold(4'hF, 8'hFF, 4);

`ifdef SEG_CAPTURE_DP_EN
    hold(4'b1101, 8'h12, 10);
    check("dp_sec", 32'(sec), 32'd5);
    check("dp_bit", 32'(dp_out[1]), 32'd1);
`else
    for (int k = 0; k < 10; k++) step(4'b1101, (k % 2 == 1) ? 8'h92 : 8'h12, 0);
    check("dp_toggle_sec", 32'(sec), 32'd5);
    check("dp_toggle_valid", 32'(digit_valid[1]), 32'd1);
    check("dp_off", 32'(dp_out), 32'd0);
`endif
    hold(4'hF, 8'hFF, 3);

    // randomized dwells against the model
    begin
      logic [3:0] an, last_an;
      logic [7:0] seg;
      int         r, n;
      last_an = 4'b1110;
      for (int d = 0; d < 250; d++) begin
        r = $urandom_range(0, 9);
        if (r <= 5) an = slot_codes[$urandom_range(0, 3)];
        else if (r == 6) an = 4'hF;
        else if (r == 7) an = 4'($urandom_range(0, 15));
        else an = last_an;
        if ($urandom_range(0, 5) == 0) seg[6:0] = 7'($urandom_range(0, 127));
        else seg[6:0] = pat_tab[$urandom_range(0, 9)];
        seg[7] = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 8);
        if ($urandom_range(0, 19) == 0) begin
          an = 4'hF;
          n = TIMEOUT + $urandom_range(0, 30);
        end
        if ($urandom_range(0, 29) == 0) step(an, seg, 1);
        hold(an, seg, n);
        last_an = an;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
